// File: rtl/uart_receiver.sv
// UART receive path: 2-flop rx synchroniser, start-edge detect, mid-bit sampling
// on the shared 16x baud tick, LSB-first byte assembly with framing-error flag.
module uart_receiver #(
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned SB_TICK   = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 Tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 rx_done,
  output logic                 frame_error,
  output logic                 rx_busy
);

  localparam int unsigned BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);
  localparam logic [3:0]    STOP_LAST = 4'(SB_TICK - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t               state, state_n;
  logic                 rx_meta, rx_s, rx_prev;
  logic [3:0]           tick_cnt, tick_n;
  logic [BW-1:0]        bit_cnt, bit_n;
  logic [DATA_BITS-1:0] shreg, sh_n, dout_n;
  logic                 done_n, fe_n;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx_meta     <= 1'b1;
      rx_s        <= 1'b1;
      rx_prev     <= 1'b1;
      state       <= IDLE;
      tick_cnt    <= '0;
      bit_cnt     <= '0;
      shreg       <= '0;
      data_out    <= '0;
      rx_done     <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      rx_meta     <= rx;
      rx_s        <= rx_meta;
      rx_prev     <= rx_s;
      state       <= state_n;
      tick_cnt    <= tick_n;
      bit_cnt     <= bit_n;
      shreg       <= sh_n;
      data_out    <= dout_n;
      rx_done     <= done_n;
      frame_error <= fe_n;
    end
  end

  always_comb begin
    state_n = state;
    tick_n  = tick_cnt;
    bit_n   = bit_cnt;
    sh_n    = shreg;
    dout_n  = data_out;
    done_n  = 1'b0;
    fe_n    = frame_error;
    unique case (state)
      IDLE: begin
        // Edge detect is not gated by Tick; a coincident Tick is simply dropped.
        if (rx_prev && !rx_s) begin
          state_n = START;
          tick_n  = '0;
        end
      end
      START: begin
        if (Tick) begin
          if (tick_cnt == 4'd7) begin
            if (!rx_s) begin
              state_n = DATA;
              tick_n  = '0;
              bit_n   = '0;
            end else begin
              state_n = IDLE;
            end
          end else begin
            tick_n = tick_cnt + 4'd1;
          end
        end
      end
      DATA: begin
        if (Tick) begin
          if (tick_cnt == 4'd15) begin
            sh_n              = shreg >> 1;
            sh_n[DATA_BITS-1] = rx_s;
            tick_n            = '0;
            if (bit_cnt == LAST_BIT) state_n = STOP;
            else                     bit_n   = bit_cnt + BW'(1);
          end else begin
            tick_n = tick_cnt + 4'd1;
          end
        end
      end
      STOP: begin
        if (Tick) begin
          if (tick_cnt == STOP_LAST) begin
            dout_n  = shreg;
            fe_n    = ~rx_s;
            done_n  = 1'b1;
            state_n = IDLE;
          end else begin
            tick_n = tick_cnt + 4'd1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign rx_busy = (state != IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// Randomised frame-level bench for uart_receiver; expected bytes/flags come from
// the bits the bench puts on the line, delivered in order through a queue.
module tb_uart_receiver;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       Tick  = 1'b0;
  logic       rx    = 1'b1;
  logic [7:0] data_out;
  logic       rx_done, frame_error, rx_busy;

  int unsigned total = 0;
  int unsigned bad   = 0;
  int unsigned tick_period = 54;
  int unsigned tcnt  = 0;

  logic [8:0] exp_q[$];     // {frame_error, byte}
  logic [7:0] last_data = '0;
  logic       last_fe   = 1'b0;
  logic       prev_done = 1'b0;

  uart_receiver #(.DATA_BITS(8), .SB_TICK(16)) dut (
    .clock(clock), .reset(reset), .Tick(Tick), .rx(rx),
    .data_out(data_out), .rx_done(rx_done),
    .frame_error(frame_error), .rx_busy(rx_busy)
  );

  always #5 clock = ~clock;

  // Tick is high for one full clock every tick_period clocks.
  always @(posedge clock) begin
    #2;
    if (tcnt + 1 >= tick_period) begin
      tcnt = 0;
      Tick = 1'b1;
    end else begin
      tcnt++;
      Tick = 1'b0;
    end
  end

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (rx_done) begin
      check("done_gap", prev_done, 0);
      if (exp_q.size() == 0) begin
        check("extra_done", rx_done, 0);
      end else begin
        logic [8:0] e;
        e = exp_q.pop_front();
        check("data", data_out, e[7:0]);
        check("ferr", frame_error, e[8]);
        last_data = e[7:0];
        last_fe   = e[8];
      end
    end
    prev_done = rx_done;
  end

  function automatic int unsigned bitc();
    return 16 * tick_period;
  endfunction

  task automatic idle(input int unsigned n);
    repeat (n) @(negedge clock);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_ok);
    exp_q.push_back({~stop_ok, b});
    rx = 1'b0;
    idle(bitc());
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      idle(bitc());
    end
    rx = stop_ok;
    idle(bitc());
    if (!stop_ok) begin
      rx = 1'b1;
      idle(bitc());
    end
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 2 * bitc() && exp_q.size() != 0; i++) @(negedge clock);
    check(tag, exp_q.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    int unsigned n;
    #1 reset = 1'b1;
    #1;
    check("rst_data", data_out, 0);
    check("rst_done", rx_done, 0);
    check("rst_ferr", frame_error, 0);
    check("rst_busy", rx_busy, 0);
    idle(3);
    reset = 1'b0;

    // Line idle: nothing may happen.
    idle(1000);
    check("idle_data", data_out, 0);
    check("idle_ferr", frame_error, 0);
    check("idle_busy", rx_busy, 0);

    // 0xA5 at 54-clock ticks. rx falls in a Tick cycle, which the DUT ignores
    // while still idle; 152 further ticks at 54 clocks put rx_done 152*54+1 clocks out.
    for (int i = 0; i < 100 && !Tick; i++) @(negedge clock);
    n = 0;
    fork
      send_frame(8'hA5, 1'b1);
      begin
        while (!rx_done && n < 20000) begin
          @(negedge clock);
          n++;
        end
      end
      begin
        idle(2000);
        check("busy_mid", rx_busy, 1);
      end
    join
    check("latency", n, 152 * 54 + 1);
    drain("drain_a5");

    tick_period = 6;
    idle(50);

    send_frame(8'h3C, 1'b0);
    send_frame(8'h81, 1'b1);
    drain("drain_3c81");

    // Short low glitch must abort in START.
    rx = 1'b0;
    idle(3 * tick_period);
    rx = 1'b1;
    idle(2 * bitc());
    check("glitch_data", data_out, last_data);
    check("glitch_busy", rx_busy, 0);
    send_frame(8'h55, 1'b1);
    drain("drain_55");

    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    send_frame(8'h7E, 1'b1);
    exp_q.push_back({1'b1, 8'h00});
    rx = 1'b0;
    idle(20 * bitc());
    check("break_idle", rx_busy, 0);
    rx = 1'b1;
    idle(2 * bitc());
    drain("drain_break");
    send_frame(8'h5A, 1'b1);
    drain("drain_5a");

    for (int k = 0; k < 8; k++) begin
      send_frame(8'($urandom), ($urandom_range(0, 3) != 0));
      idle($urandom_range(0, 200));
    end
    drain("drain_rand");

    // Async reset in mid data bit 4 after a framing-error frame.
    send_frame(8'h99, 1'b0);
    drain("drain_99");
    rx = 1'b0;
    idle(bitc());
    for (int i = 0; i < 4; i++) begin
      rx = 1'(8'hC3 >> i);
      idle(bitc());
    end
    rx = 1'b0;
    idle(bitc() / 2);
    check("pre_rst_busy", rx_busy, 1);
    #2 reset = 1'b1;
    #1;
    check("arst_data", data_out, 0);
    check("arst_done", rx_done, 0);
    check("arst_ferr", frame_error, 0);
    check("arst_busy", rx_busy, 0);
    last_data = '0;
    last_fe   = 1'b0;
    rx = 1'b1;
    idle(3);
    reset = 1'b0;
    idle(2 * bitc());
    send_frame(8'hC3, 1'b1);
    drain("drain_c3");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
